// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES registered ripple segments,
// with valid/ready flow control; the whole pipeline holds while the result is blocked.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;
    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        logic [WIDTH-1:0] r_a, r_b, r_s;
        logic             r_c, r_v;
        logic [WIDTH-1:0] w_a, w_b, w_s, w_sn;
        logic             w_ci, w_v;
        logic [CHUNK:0]   w_add;
        if (k == 0) begin : g_in
            assign w_a  = a;
            assign w_b  = sub ? ~b : b;
            assign w_ci = sub | cin;
            assign w_s  = '0;
            assign w_v  = in_valid;
        end else begin : g_mid
            assign w_a  = g_seg[k-1].r_a;
            assign w_b  = g_seg[k-1].r_b;
            assign w_ci = g_seg[k-1].r_c;
            assign w_s  = g_seg[k-1].r_s;
            assign w_v  = g_seg[k-1].r_v;
        end
        assign w_add = {1'b0, w_a[k*CHUNK +: CHUNK]} + {1'b0, w_b[k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, w_ci};
        // lower slices already summed travel unchanged; this segment fills its own slice
        always_comb begin
            w_sn = w_s;
            w_sn[k*CHUNK +: CHUNK] = w_add[CHUNK-1:0];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_a <= '0;
                r_b <= '0;
                r_s <= '0;
                r_c <= 1'b0;
            end else if (w_adv) begin
                r_v <= w_v;
                r_a <= w_a;
                r_b <= w_b;
                r_s <= w_sn;
                r_c <= w_add[CHUNK];
            end
        end
    end
    assign out_valid = g_seg[STAGES-1].r_v;
    assign sum       = g_seg[STAGES-1].r_s;
    assign cout      = g_seg[STAGES-1].r_c;
    assign ovf       = (g_seg[STAGES-1].r_a[WIDTH-1] == g_seg[STAGES-1].r_b[WIDTH-1])
                    && (g_seg[STAGES-1].r_s[WIDTH-1] != g_seg[STAGES-1].r_a[WIDTH-1]);
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; successor to the 4-bit combinational ripple-carry adder.
- Splits a WIDTH-bit carry chain into STAGES registered ripple segments, so timing is set by the segment length rather than the full width.
- Adds an add/subtract mode, signed-overflow detection and a valid/ready handshake with backpressure.
- Used as the datapath adder for wider accumulators and ALUs in the design.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline segments (1..WIDTH). CHUNK = WIDTH/STAGES bits are summed per segment.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation present on a, b, cin, sub.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 with cin ignored.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; for sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits clear, so out_valid=0;
  - sum=0, cout=0, ovf=0;
  - operand, carry and partial-sum registers cleared;
  - in_ready=1 once rst_n is high.
- Stall enable: adv = !out_valid || out_ready. in_ready = adv, combinational.
- Transfer rules:
  - An input transfers when in_valid && in_ready.
  - An output transfers when out_valid && out_ready.
- The pipeline advances as a whole only when adv=1. When adv=0, every stage register holds and inputs are not accepted. No bubble collapsing.
- Operand preprocessing at stage 0:
  - b_eff = sub ? ~b : b;
  - c_eff = sub ? 1 : cin.
- Segment k (0..STAGES-1) handles bits [k*CHUNK +: CHUNK]:
  - ripple-adds that slice of a and b_eff with the carry registered by segment k-1 (c_eff for k=0);
  - registers the slice sum and its carry-out.
- Unprocessed upper slices of a and b_eff, and already-computed lower sum slices, travel with the operation in skew registers.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stalls. Throughput is 1 op/cycle when out_ready=1.
- cout = carry out of the last segment.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]). Operand MSBs are carried in the pipeline for this.
- Outputs are registered (final stage registers) and held stable while out_valid && !out_ready.
- Ordering: results emerge in input order; no operation is dropped or duplicated.
- Bubbles: an in_valid=0 cycle with adv=1 inserts a bubble, and that stage's valid bit is 0.
- Simultaneous input and output transfer in the same cycle is allowed and sustains full rate.
- Data at invalid stages is don't-care. The sum/cout/ovf values when out_valid=0 are not checked.
- Wrap-around: sum is modulo 2^WIDTH, with the overflow reported on cout/ovf. The operation itself is never saturated.
- STAGES=1 degenerates to a single registered WIDTH-bit ripple adder with latency 1.
- Reset mid-operation: every in-flight operation is discarded, and no result for it ever appears.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1; a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later out_valid=1, sum=0x0000, cout=1, ovf=0.
- sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- a=0x7FFF, b=0x0001, cin=1, sub=0 -> sum=0x8001, cout=0, ovf=1. Also a=0x1234, b=0x4321, cin=1 -> sum=0x5556.
- Back-to-back stream of 8 random ops with out_ready low for 3 cycles mid-stream:
  - in_ready drops the same cycle;
  - outputs are held stable while stalled;
  - all 8 results are correct and in order against a reference model.
- Load 3 ops, assert rst_n=0 for 1 cycle mid-flight -> out_valid=0 immediately; none of the 3 results ever appear; the next op after reset has latency 4.
- Rerun the random stream with STAGES=1 and STAGES=16 (WIDTH=16) -> latency 1 and 16 respectively, with results matching the reference model.
